// File: rtl/vga_display_unit_pkg.sv
// Shared VGA 640x480@60 timing constants, canvas geometry and pixel packing
// for the display unit and its timing generator.
package vga_display_unit_pkg;

    localparam logic [9:0] H_ACTIVE     = 10'd640;
    localparam logic [9:0] H_FP         = 10'd16;
    localparam logic [9:0] H_SYNC       = 10'd96;
    localparam logic [9:0] H_BP         = 10'd48;
    localparam logic [9:0] H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam logic [9:0] H_SYNC_START = H_ACTIVE + H_FP;
    localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC - 10'd1;

    localparam logic [9:0] V_ACTIVE     = 10'd480;
    localparam logic [9:0] V_FP         = 10'd10;
    localparam logic [9:0] V_SYNC       = 10'd2;
    localparam logic [9:0] V_BP         = 10'd33;
    localparam logic [9:0] V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] V_SYNC_START = V_ACTIVE + V_FP;
    localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC - 10'd1;

    localparam logic [9:0] CANVAS_SIZE  = 10'd256;
    localparam logic [9:0] CANVAS_X0    = 10'd192;
    localparam logic [9:0] CANVAS_Y0    = 10'd112;
    localparam logic [9:0] CANVAS_X1    = CANVAS_X0 + CANVAS_SIZE;
    localparam logic [9:0] CANVAS_Y1    = CANVAS_Y0 + CANVAS_SIZE;

    localparam logic [7:0] CUR_RESET    = 8'h80;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    function automatic logic within2(input logic signed [8:0] d);
        return (d >= -9'sd2) && (d <= 9'sd2);
    endfunction

endpackage

// File: rtl/vga_display_unit_if.sv
// VRAM read port, pen position and video outputs of the display unit.
// master = display unit side, slave = VRAM / pen / monitor side.
interface vga_display_unit_if;
    logic [11:0] vdata;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] vaddr;
    logic [3:0]  disr;
    logic [3:0]  disg;
    logic [3:0]  disb;
    logic        hs;
    logic        vs;

    modport master (input vdata, x, y, output vaddr, disr, disg, disb, hs, vs);
    modport slave  (output vdata, x, y, input vaddr, disr, disg, disb, hs, vs);
endinterface

// File: rtl/vga_display_unit_timing_gen.sv
// Free-running 800x525 pixel/line counters with raw active-low syncs and
// active/canvas region flags, all combinational from the current count.
module vga_timing_gen
    import vga_display_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] hcnt_o,
    output logic [9:0] vcnt_o,
    output logic       hs_raw_o,
    output logic       vs_raw_o,
    output logic       active_o,
    output logic       canvas_o
);

    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;

    always_comb begin
        hcnt_d = hcnt_q + 10'd1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_TOTAL - 10'd1) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_TOTAL - 10'd1) ? '0 : vcnt_q + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign hcnt_o   = hcnt_q;
    assign vcnt_o   = vcnt_q;
    assign hs_raw_o = !((hcnt_q >= H_SYNC_START) && (hcnt_q <= H_SYNC_END));
    assign vs_raw_o = !((vcnt_q >= V_SYNC_START) && (vcnt_q <= V_SYNC_END));
    assign active_o = (hcnt_q < H_ACTIVE) && (vcnt_q < V_ACTIVE);
    assign canvas_o = (hcnt_q >= CANVAS_X0) && (hcnt_q < CANVAS_X1) &&
                      (vcnt_q >= CANVAS_Y0) && (vcnt_q < CANVAS_Y1);

endmodule

// File: rtl/vga_display_unit.sv
// VGA display stage: canvas VRAM addressing, 2-clk colour/sync pipeline and,
// when CURSOR_EN is defined, an inverting cursor cross at the latched pen position.
module vga_display_unit
    import vga_display_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    vga_display_unit_if.master bus
);

    logic [9:0] hcnt, vcnt;
    logic       hs_raw, vs_raw, active, canvas;

    vga_timing_gen u_timing (
        .clk      (clk),
        .rst      (rst),
        .hcnt_o   (hcnt),
        .vcnt_o   (vcnt),
        .hs_raw_o (hs_raw),
        .vs_raw_o (vs_raw),
        .active_o (active),
        .canvas_o (canvas)
    );

    logic [7:0] cx, cy;
    logic       cursor_hit;

    assign cx        = 8'(hcnt - CANVAS_X0);
    assign cy        = 8'(vcnt - CANVAS_Y0);
    assign bus.vaddr = canvas ? {cx, cy} : 16'h0000;

`ifdef CURSOR_EN
    logic [7:0]        cur_x_q, cur_y_q;
    logic signed [8:0] dx, dy;

    assign dx = $signed({1'b0, cx} - {1'b0, cur_x_q});
    assign dy = $signed({1'b0, cy} - {1'b0, cur_y_q});
    // Clipping comes for free: cx/cy only exist inside the canvas.
    assign cursor_hit = canvas && (((dx == 9'sd0) && within2(dy)) ||
                                   ((dy == 9'sd0) && within2(dx)));

    // Pen position sampled once per frame so the cross never tears.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_x_q <= CUR_RESET;
            cur_y_q <= CUR_RESET;
        end else if ((hcnt == 10'd0) && (vcnt == 10'd0)) begin
            cur_x_q <= bus.x;
            cur_y_q <= bus.y;
        end
    end
`else
    logic unused_pos;
    assign cursor_hit = 1'b0;
    assign unused_pos = ^{bus.x, bus.y};
`endif

    logic [1:0] hs_dly_q, vs_dly_q;
    logic       vis_q, inv_q;
    rgb_t       pix_q, pix_d;

    always_comb begin
        pix_d = '0;
        if (vis_q)
            pix_d = inv_q ? ~bus.vdata : bus.vdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_dly_q <= 2'b11;
            vs_dly_q <= 2'b11;
            vis_q    <= 1'b0;
            inv_q    <= 1'b0;
            pix_q    <= '0;
        end else begin
            hs_dly_q <= {hs_dly_q[0], hs_raw};
            vs_dly_q <= {vs_dly_q[0], vs_raw};
            vis_q    <= active && canvas;
            inv_q    <= cursor_hit;
            pix_q    <= pix_d;
        end
    end

    assign bus.hs   = hs_dly_q[1];
    assign bus.vs   = vs_dly_q[1];
    assign bus.disr = pix_q.r;
    assign bus.disg = pix_q.g;
    assign bus.disb = pix_q.b;

endmodule
